// File: rtl/i2c_slave_pkg.sv
// i2c_slave_pkg
// Shared types and constants for the I2C target responder.
//   state_e            : responder FSM states
//   I2C_ACK / I2C_NACK : SDA level of the acknowledge bit
//   I2C_RW_READ        : R/W bit value for a read transfer
//   DEFAULT_SLAVE_ADDR : 7-bit address answered when not overridden
package i2c_slave_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        RX        = 3'd3,
        RX_ACK    = 3'd4,
        TX        = 3'd5,
        TX_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } state_e;

    localparam logic       I2C_ACK            = 1'b0;
    localparam logic       I2C_NACK           = 1'b1;
    localparam logic       I2C_RW_READ        = 1'b1;
    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h2A;

endpackage

// File: rtl/i2c_slave_responder_filter.sv
// i2c_line_filter
// Conditions one asynchronous bus line: 2-flop synchronizer, then a
// stability filter that only accepts a new level after it has been seen on
// FILTER_LEN consecutive pclk cycles, then 1-cycle edge strobes.
// Ports:
//   pclk, preset : clock, async active-low reset
//   line_i       : raw bus level
//   filt_o       : filtered level (resets to 1, the idle bus level)
//   rise_o/fall_o: 1-cycle strobes on filt_o edges
module i2c_line_filter
    import i2c_slave_pkg::*;
#(
    parameter int FILTER_LEN = 3
) (
    input  logic pclk,
    input  logic preset,
    input  logic line_i,
    output logic filt_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int             CW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(FILTER_LEN - 1);

    logic          sync1_q, sync2_q;
    logic          filt_q, filt_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Down-counter restarts whenever the synced level agrees with the
    // filtered one; a differing level is accepted at terminal count.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = CNT_LOAD;
        if (sync2_q != filt_q) begin
            if (cnt_q == '0) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= CNT_LOAD;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            prev_q  <= filt_q;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_o = filt_q;
    assign rise_o = filt_q & ~prev_q;
    assign fall_o = ~filt_q & prev_q;

endmodule

// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder
// I2C target: detects START/STOP on the oversampled bus, matches a 7-bit
// address, receives write bytes and transmits read bytes from a local tx port.
// Ports:
//   pclk, preset                  : clock (>= 8x SCL), async active-low reset
//   scl_i, sda_i                  : raw bus levels
//   sda_oe, scl_oe                : 1 = pull line low
//   data_slave_read(_valid)       : received write byte + 1-cycle strobe
//   tx_data, tx_valid, tx_req     : read-byte source; tx_req = byte taken at next SCL fall
//   start, stop                   : 1-cycle condition strobes
//   busy                          : START seen, STOP not yet
// Build option: define I2C_SLAVE_CLK_STRETCH_EN to hold SCL low on a tx
// underrun instead of sending 8'hFF.
//
// state     | meaning
// IDLE      | bus free or not addressed, waiting for START
// ADDR      | shifting in address + R/W
// ADDR_ACK  | driving ACK for matched address
// RX        | receiving a write data byte
// RX_ACK    | driving ACK for a received byte
// TX        | shifting out a read byte
// TX_ACK    | SDA released, sampling master ACK/NACK
// WAIT_STOP | not addressed or master NACKed; ignore bus until STOP
module i2c_slave_responder
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
    parameter int         FILTER_LEN = 3
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic [7:0] data_slave_read,
    output logic       data_slave_read_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_req,
    output logic       start,
    output logic       stop,
    output logic       busy
);

    logic scl_filt, scl_rise, scl_fall;
    logic sda_filt, sda_rise, sda_fall;
    logic start_det, stop_det;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic [6:0] tx_shift_q, tx_shift_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rvalid_q, rvalid_d;
    logic       tx_req_q, tx_req_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;
    logic       busy_q, busy_d;
    logic [7:0] rx_byte;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    logic       scl_oe_q, scl_oe_d;
`else
    logic [7:0] tx_byte;
`endif

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .pclk   (pclk),
        .preset (preset),
        .line_i (scl_i),
        .filt_o (scl_filt),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .pclk   (pclk),
        .preset (preset),
        .line_i (sda_i),
        .filt_o (sda_filt),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    // Both lines share the same filter latency, so their relative order is kept.
    assign start_det = sda_fall & scl_filt;
    assign stop_det  = sda_rise & scl_filt;

    // States are entered on scl_rise; SDA is only changed on scl_fall, so each
    // ACK state drives/releases on its fall and leaves on the following rise.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        tx_req_d   = 1'b0;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        busy_d     = busy_q;
        rx_byte    = {rx_shift_q, sda_filt};
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        scl_oe_d   = scl_oe_q;
`else
        tx_byte    = tx_valid ? tx_data : 8'hFF;
`endif

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            start_d   = 1'b1;
            busy_d    = 1'b1;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
            scl_oe_d  = 1'b0;
`endif
        end else if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            stop_d   = 1'b1;
            busy_d   = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
            scl_oe_d = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        rx_shift_d = rx_byte[6:0];
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rw_d    = rx_byte[0];
                            state_d = (rx_byte[7:1] == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b1;
                    end else if (scl_rise) begin
                        if (rw_q == I2C_RW_READ) begin
                            state_d  = TX;
                            tx_req_d = 1'b1;
                        end else begin
                            state_d = RX;
                        end
                    end
                end
                RX: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_rise) begin
                        rx_shift_d = rx_byte[6:0];
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rdata_d  = rx_byte;
                            rvalid_d = 1'b1;
                            state_d  = RX_ACK;
                        end
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b1;
                    end else if (scl_rise) begin
                        state_d = RX;
                    end
                end
                TX: begin
                    if (scl_fall) begin
                        // Bit counter at 0 on a fall marks the byte boundary.
                        if (bit_cnt_q == 3'd0) begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                            if (tx_valid) begin
                                tx_shift_d = tx_data[6:0];
                                sda_oe_d   = ~tx_data[7];
                            end else begin
                                scl_oe_d = 1'b1;
                            end
`else
                            tx_shift_d = tx_byte[6:0];
                            sda_oe_d   = ~tx_byte[7];
`endif
                        end else begin
                            tx_shift_d = {tx_shift_q[5:0], 1'b1};
                            sda_oe_d   = ~tx_shift_q[6];
                        end
                    end else if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = TX_ACK;
                        end
                    end
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                    // SCL is held low here, so no strobes compete with this load.
                    if (scl_oe_q && tx_valid) begin
                        tx_shift_d = tx_data[6:0];
                        sda_oe_d   = ~tx_data[7];
                        scl_oe_d   = 1'b0;
                    end
`endif
                end
                TX_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_rise) begin
                        if (sda_filt == I2C_ACK) begin
                            state_d  = TX;
                            tx_req_d = 1'b1;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                WAIT_STOP: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            rx_shift_q <= 7'd0;
            tx_shift_q <= 7'd0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            rdata_q    <= 8'h00;
            rvalid_q   <= 1'b0;
            tx_req_q   <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            tx_req_q   <= tx_req_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            busy_q     <= busy_d;
        end
    end

`ifdef I2C_SLAVE_CLK_STRETCH_EN
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            scl_oe_q <= 1'b0;
        end else begin
            scl_oe_q <= scl_oe_d;
        end
    end
    assign scl_oe = scl_oe_q;
`else
    assign scl_oe = 1'b0;
`endif

    assign sda_oe                = sda_oe_q;
    assign data_slave_read       = rdata_q;
    assign data_slave_read_valid = rvalid_q;
    assign tx_req                = tx_req_q;
    assign start                 = start_q;
    assign stop                  = stop_q;
    assign busy                  = busy_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
module tb_i2c_slave_responder;

    localparam int Q = 10;   // quarter SCL period in pclk cycles

    logic       pclk = 1'b0;
    logic       preset;
    logic       scl_m, sda_m;
    logic       scl_bus, sda_bus;
    logic       sda_oe, scl_oe;
    logic [7:0] data_slave_read;
    logic       data_slave_read_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_req, start, stop, busy;

    int checks = 0;
    int errors = 0;

    int valid_total = 0, start_total = 0, stop_total = 0, txreq_total = 0;
    int oe_cycles = 0, scloe_cycles = 0;
    logic [7:0] rx_log [0:63];

    always #5 pclk = ~pclk;

    assign scl_bus = scl_m & ~scl_oe;
    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave_responder dut (
        .pclk                  (pclk),
        .preset                (preset),
        .scl_i                 (scl_bus),
        .sda_i                 (sda_bus),
        .sda_oe                (sda_oe),
        .scl_oe                (scl_oe),
        .data_slave_read       (data_slave_read),
        .data_slave_read_valid (data_slave_read_valid),
        .tx_data               (tx_data),
        .tx_valid              (tx_valid),
        .tx_req                (tx_req),
        .start                 (start),
        .stop                  (stop),
        .busy                  (busy)
    );

    always @(negedge pclk) begin
        if (data_slave_read_valid) begin
            rx_log[valid_total[5:0]] = data_slave_read;
            valid_total++;
        end
        if (start)  start_total++;
        if (stop)   stop_total++;
        if (tx_req) txreq_total++;
        if (sda_oe) oe_cycles++;
        if (scl_oe) scloe_cycles++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(posedge pclk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic send_bit(input logic b, output logic s);
        int n;
        sda_m = b;
        wait_q();
        scl_m = 1'b1;
        n = 0;
        while (scl_bus !== 1'b1 && n < 1000) begin
            @(posedge pclk);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL scl_release: SCL still low after %0d cycles, required high", n);
        end
        wait_q();
        @(negedge pclk);
        s = sda_bus;
        wait_q();
        scl_m = 1'b0;
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(d[i], s);
        send_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack_bit, input logic [7:0] next_tx, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            d[i] = s;
        end
        tx_data = next_tx;
        send_bit(ack_bit, s);
    endtask

    typedef struct {
        logic [7:0] addr_byte;
        logic [7:0] d0;
        logic [7:0] d1;
        int         nbytes;
        logic       exp_ack;
        int         exp_valids;
    } wvec_t;

    wvec_t vecs [4];
    logic  ack;
    logic  s;
    logic [7:0] rd;
    logic [5:0] idx;
    int v0, s0, p0, o0, t0, c0, snap;

    initial begin
        vecs[0] = '{8'h54, 8'hA5, 8'h3C, 2, 1'b0, 2};
        vecs[1] = '{8'h56, 8'h11, 8'h00, 1, 1'b1, 0};
        vecs[2] = '{8'h54, 8'h00, 8'hFF, 2, 1'b0, 2};
        vecs[3] = '{8'hD4, 8'h5A, 8'h00, 1, 1'b1, 0};

        preset = 1'b0; scl_m = 1'b1; sda_m = 1'b1; tx_data = 8'h00; tx_valid = 1'b0;
        repeat (5) @(posedge pclk);
        @(negedge pclk);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_scl_oe", scl_oe, 0);
        chk("rst_data", data_slave_read, 8'h00);
        chk("rst_pulses", {data_slave_read_valid, tx_req, start, stop}, 4'b0000);
        chk("rst_busy", busy, 0);
        preset = 1'b1;
        repeat (20) @(posedge pclk);

        // Write transfers, matching and non-matching address.
        for (int v = 0; v < 4; v++) begin
            v0 = valid_total; s0 = start_total; p0 = stop_total; o0 = oe_cycles;
            i2c_start();
            write_byte(vecs[v].addr_byte, ack);
            chk($sformatf("w%0d_addr_ack", v), ack, vecs[v].exp_ack);
            write_byte(vecs[v].d0, ack);
            chk($sformatf("w%0d_d0_ack", v), ack, vecs[v].exp_ack);
            if (vecs[v].nbytes > 1) begin
                write_byte(vecs[v].d1, ack);
                chk($sformatf("w%0d_d1_ack", v), ack, vecs[v].exp_ack);
            end
            @(negedge pclk);
            chk($sformatf("w%0d_busy_pre", v), busy, 1);
            i2c_stop();
            @(negedge pclk);
            chk($sformatf("w%0d_busy_post", v), busy, 0);
            chk($sformatf("w%0d_valids", v), valid_total - v0, vecs[v].exp_valids);
            chk($sformatf("w%0d_starts", v), start_total - s0, 1);
            chk($sformatf("w%0d_stops", v), stop_total - p0, 1);
            chk($sformatf("w%0d_drove", v), (oe_cycles - o0) > 0, !vecs[v].exp_ack);
            if (vecs[v].exp_valids > 0) begin
                idx = 6'(v0);
                chk($sformatf("w%0d_data0", v), rx_log[idx], vecs[v].d0);
            end
            if (vecs[v].exp_valids > 1) begin
                idx = 6'(v0 + 1);
                chk($sformatf("w%0d_data1", v), rx_log[idx], vecs[v].d1);
            end
            wait_q();
        end

        // Read: ACK then NACK, then confirm the target stays off the bus.
        tx_data = 8'h96; tx_valid = 1'b1;
        t0 = txreq_total; p0 = stop_total;
        i2c_start();
        write_byte(8'h55, ack);
        chk("rd_addr_ack", ack, 0);
        read_byte(1'b0, 8'h5A, rd);
        chk("rd_byte0", rd, 8'h96);
        read_byte(1'b1, 8'h00, rd);
        chk("rd_byte1", rd, 8'h5A);
        chk("rd_txreq", txreq_total - t0, 2);
        read_byte(1'b1, 8'h00, rd);
        chk("rd_waitstop_idle", rd, 8'hFF);
        chk("rd_txreq_after_nack", txreq_total - t0, 2);
        @(negedge pclk);
        chk("rd_busy_pre", busy, 1);
        i2c_stop();
        @(negedge pclk);
        chk("rd_busy_post", busy, 0);
        chk("rd_stop", stop_total - p0, 1);
        wait_q();

        // Repeated START after 4 data bits discards the partial byte.
        v0 = valid_total; s0 = start_total;
        i2c_start();
        write_byte(8'h54, ack);
        chk("rs_addr_ack", ack, 0);
        send_bit(1'b1, s); send_bit(1'b0, s); send_bit(1'b1, s); send_bit(1'b0, s);
        i2c_start();
        write_byte(8'h54, ack);
        chk("rs_addr2_ack", ack, 0);
        write_byte(8'h0F, ack);
        chk("rs_data_ack", ack, 0);
        i2c_stop();
        chk("rs_valids", valid_total - v0, 1);
        idx = 6'(v0);
        chk("rs_data", rx_log[idx], 8'h0F);
        chk("rs_starts", start_total - s0, 2);
        wait_q();

        // Reset in the middle of bit 5 of a transmitted byte.
        tx_data = 8'h00; tx_valid = 1'b1;
        i2c_start();
        write_byte(8'h55, ack);
        chk("pr_addr_ack", ack, 0);
        rd = 8'hFF;
        for (int i = 7; i >= 4; i--) begin
            send_bit(1'b1, s);
            rd[i] = s;
        end
        chk("pr_partial_bits", rd[7:4], 4'h0);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        @(negedge pclk);
        chk("pr_driving_before", sda_oe, 1);
        snap = start_total + stop_total + valid_total + txreq_total;
        preset = 1'b0;
        #1;
        chk("pr_sda_released", sda_oe, 0);
        chk("pr_busy_cleared", busy, 0);
        wait_q();
        scl_m = 1'b0; wait_q();
        preset = 1'b1;
        repeat (30) @(posedge pclk);
        @(negedge pclk);
        chk("pr_no_pulses", start_total + stop_total + valid_total + txreq_total - snap, 0);
        v0 = valid_total;
        i2c_start();
        write_byte(8'h54, ack);
        chk("pr_addr2_ack", ack, 0);
        write_byte(8'h77, ack);
        chk("pr_data_ack", ack, 0);
        i2c_stop();
        chk("pr_valids", valid_total - v0, 1);
        idx = 6'(v0);
        chk("pr_data", rx_log[idx], 8'h77);
        wait_q();

`ifdef I2C_SLAVE_CLK_STRETCH_EN
        // Underrun with stretching: SCL held until tx_valid, byte still correct.
        tx_valid = 1'b0; tx_data = 8'h00;
        c0 = scloe_cycles;
        i2c_start();
        write_byte(8'h55, ack);
        chk("st_addr_ack", ack, 0);
        fork
            read_byte(1'b1, 8'h00, rd);
            begin
                repeat (30) @(posedge pclk);
                tx_data = 8'hC3;
                tx_valid = 1'b1;
            end
        join
        chk("st_byte", rd, 8'hC3);
        chk("st_stretch_len", ((scloe_cycles - c0) >= 25) && ((scloe_cycles - c0) <= 45), 1);
        i2c_stop();
        wait_q();
`else
        // Underrun without stretching: bus released, master reads 0xFF.
        tx_valid = 1'b0; tx_data = 8'h12;
        c0 = scloe_cycles;
        i2c_start();
        write_byte(8'h55, ack);
        chk("ur_addr_ack", ack, 0);
        read_byte(1'b1, 8'h00, rd);
        chk("ur_byte", rd, 8'hFF);
        chk("ur_no_stretch", scloe_cycles - c0, 0);
        i2c_stop();
        wait_q();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
